// File: rtl/tsc_seq_burner_pkg.sv
// Shared types and constants for the sequence-triggered burn block.
// Holds the FSM encoding, payload modes and the default seed builder.
package tsc_pkg;

  localparam int TSC_MAX_W = 4096;

  localparam int TSC_MODE_PERM  = 0;
  localparam int TSC_MODE_BURST = 1;

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } tsc_state_e;

  // Alternating 1010... pattern, bit 0 clear.
  function automatic logic [TSC_MAX_W-1:0] tsc_alt_seed(
    input int w
  );
    logic [TSC_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < TSC_MAX_W; i++) begin
      if (i < w) r[i] = (i % 2) == 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tsc_seq_burner_if.sv
// Snoop bus into the burner and its observable outputs.
// The snooped core is the master; the burner is the slave.
interface tsc_seq_burner_if #(
  parameter int STATE_W = 128,
  parameter int SEQ_LEN = 2,
  parameter int BURN_W  = 128
);

  localparam int IDX_W = $clog2(SEQ_LEN + 1);

  logic [STATE_W-1:0] state;
  logic               state_valid;
  logic               tj_trig;
  logic [IDX_W-1:0]   seq_idx;
  logic [BURN_W-1:0]  burn_q;

  modport master (
    output state,
    output state_valid,
    input  tj_trig,
    input  seq_idx,
    input  burn_q
  );

  modport slave (
    input  state,
    input  state_valid,
    output tj_trig,
    output seq_idx,
    output burn_q
  );

endinterface

// File: rtl/tsc_seq_burner_rot_reg.sv
// Payload register: loads SEED on reset, rotates right when enabled.
// Holds its value otherwise.
module tsc_rot_reg #(
  parameter int            W    = 128,
  parameter logic [W-1:0]  SEED = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (en) q_d = {q_q[0], q_q[W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= SEED;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/tsc_seq_burner.sv
// Sequence matcher that arms on SEQ_LEN consecutive valid matches and
// then drives a rotating payload, permanently or for a bounded burst.
module tsc_seq_burner
  import tsc_pkg::*;
#(
  parameter int                         STATE_W      = 128,
  parameter int                         SEQ_LEN      = 2,
  parameter logic [SEQ_LEN*STATE_W-1:0] PATTERNS     = '0,
  parameter int                         BURN_W       = 128,
  parameter logic [BURN_W-1:0]          SEED         =
    BURN_W'(tsc_alt_seed(BURN_W)),
  parameter int                         MODE         = TSC_MODE_PERM,
  parameter int                         BURST_CYCLES = 1024
) (
  input logic             clk,
  input logic             rst,
  tsc_seq_burner_if.slave bus
);

  localparam int IDX_W = $clog2(SEQ_LEN + 1);
  localparam int CNT_W =
    (BURST_CYCLES > 1) ? $clog2(BURST_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BURST_CYCLES - 1);

  tsc_state_e       state_d, state_q;
  logic [IDX_W-1:0] idx_d, idx_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             rot_en;
  logic             cur_match;
  logic             pat0_match;
  logic [BURN_W-1:0] burn;

  logic [STATE_W-1:0] pat [SEQ_LEN];

  for (genvar g = 0; g < SEQ_LEN; g++) begin : g_pat
    assign pat[g] = PATTERNS[g*STATE_W +: STATE_W];
  end

  always_comb begin
    cur_match = 1'b0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (IDX_W'(i) == idx_q) cur_match = (bus.state == pat[i]);
    end
    pat0_match = (bus.state == pat[0]);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rot_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.state_valid) begin
          if (cur_match && idx_q == LAST_IDX) begin
            state_d = S_ACTIVE;
            idx_d   = '0;
            cnt_d   = CNT_INIT;
          end else if (cur_match) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            // Restart only against the first stage; no deeper back-off.
            idx_d = pat0_match ? IDX_W'(1) : '0;
          end
        end
      end
      S_ACTIVE: begin
        rot_en = 1'b1;
        if (MODE == TSC_MODE_BURST) begin
          if (cnt_q == '0) state_d = S_IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  tsc_rot_reg #(
    .W    (BURN_W),
    .SEED (SEED)
  ) u_rot (
    .clk (clk),
    .rst (rst),
    .en  (rot_en),
    .q   (burn)
  );

  assign bus.tj_trig = (state_q == S_ACTIVE);
  assign bus.seq_idx = idx_q;
  assign bus.burn_q  = burn;

endmodule

// File: tb/tb_tsc_seq_burner.sv
// Directed bench: a 128-bit permanent-mode instance and an 8-bit
// burst-mode instance, driven on negedge and sampled 1ns after posedge.
module tb_tsc_seq_burner;

  localparam logic [127:0] P0 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  localparam logic [127:0] P1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] ALT_A = {64{2'b10}};
  localparam logic [127:0] ALT_5 = {64{2'b01}};

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   n_checks = 0;
  int   n_fails = 0;

  always #5 clk = ~clk;

  tsc_seq_burner_if #(.STATE_W(128), .SEQ_LEN(2), .BURN_W(128)) a_if ();
  tsc_seq_burner_if #(.STATE_W(128), .SEQ_LEN(2), .BURN_W(8))   b_if ();

  tsc_seq_burner #(
    .STATE_W (128),
    .SEQ_LEN (2),
    .PATTERNS({P1, P0}),
    .BURN_W  (128),
    .MODE    (0)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (a_if.slave)
  );

  tsc_seq_burner #(
    .STATE_W     (128),
    .SEQ_LEN     (2),
    .PATTERNS    ({P1, P0}),
    .BURN_W      (8),
    .SEED        (8'h01),
    .MODE        (1),
    .BURST_CYCLES(4)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (b_if.slave)
  );

  task automatic beat_a(input logic v, input logic [127:0] s);
    @(negedge clk);
    rst_a = 1'b0;
    a_if.state_valid = v;
    a_if.state = s;
    @(posedge clk);
    #1;
  endtask

  task automatic beat_b(input logic v, input logic [127:0] s);
    @(negedge clk);
    rst_b = 1'b0;
    b_if.state_valid = v;
    b_if.state = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string nm, input logic tj,
                       input logic [1:0] idx, input logic [127:0] bq);
    n_checks++;
    if (a_if.tj_trig !== tj || a_if.seq_idx !== idx ||
        a_if.burn_q !== bq) begin
      n_fails++;
      $display("FAIL %s: got tj=%b idx=%0d burn=%h, want tj=%b idx=%0d burn=%h",
               nm, a_if.tj_trig, a_if.seq_idx, a_if.burn_q, tj, idx, bq);
    end
  endtask

  task automatic chk_b(input string nm, input logic tj,
                       input logic [1:0] idx, input logic [7:0] bq);
    n_checks++;
    if (b_if.tj_trig !== tj || b_if.seq_idx !== idx ||
        b_if.burn_q !== bq) begin
      n_fails++;
      $display("FAIL %s: got tj=%b idx=%0d burn=%h, want tj=%b idx=%0d burn=%h",
               nm, b_if.tj_trig, b_if.seq_idx, b_if.burn_q, tj, idx, bq);
    end
  endtask

  task automatic test_reset;
    a_if.state = '0;
    a_if.state_valid = 1'b0;
    b_if.state = '0;
    b_if.state_valid = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_a("reset_a", 1'b0, 2'd0, ALT_A);
    chk_b("reset_b", 1'b0, 2'd0, 8'h01);
  endtask

  task automatic test_gap_trigger;
    beat_a(1'b1, P0);
    chk_a("gap_p0", 1'b0, 2'd1, ALT_A);
    beat_a(1'b0, P1 ^ 128'h5);
    chk_a("gap_hold", 1'b0, 2'd1, ALT_A);
    beat_a(1'b1, P1);
    chk_a("gap_trig", 1'b1, 2'd0, ALT_A);
    for (int i = 0; i < 4; i++) begin
      beat_a(1'b0, '0);
      chk_a($sformatf("gap_rot%0d", i), 1'b1, 2'd0,
            (i % 2 == 0) ? ALT_5 : ALT_A);
    end
  endtask

  task automatic test_ignore_active;
    // Rotation phase continues from test_gap_trigger: burn is ALT_A now.
    for (int i = 0; i < 6; i++) begin
      beat_a(1'b1, (i % 2 == 0) ? P0 : P1);
      chk_a($sformatf("ign%0d", i), 1'b1, 2'd0,
            (i % 2 == 0) ? ALT_5 : ALT_A);
    end
  endtask

  task automatic reset_a_once;
    @(negedge clk);
    rst_a = 1'b1;
    a_if.state_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_a("rst_mid_active_a", 1'b0, 2'd0, ALT_A);
  endtask

  task automatic test_mismatch_restart;
    beat_a(1'b1, P0);
    chk_a("mm_p0a", 1'b0, 2'd1, ALT_A);
    beat_a(1'b1, P0);
    chk_a("mm_p0b", 1'b0, 2'd1, ALT_A);
    beat_a(1'b1, P1);
    chk_a("mm_trig", 1'b1, 2'd0, ALT_A);
    reset_a_once();
    beat_a(1'b1, P0);
    chk_a("nt_p0", 1'b0, 2'd1, ALT_A);
    beat_a(1'b1, '0);
    chk_a("nt_zero", 1'b0, 2'd0, ALT_A);
    beat_a(1'b1, P1);
    chk_a("nt_p1", 1'b0, 2'd0, ALT_A);
    beat_a(1'b0, '0);
    chk_a("nt_idle", 1'b0, 2'd0, ALT_A);
  endtask

  task automatic test_burst;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h80;
    exp_b[1] = 8'h40;
    exp_b[2] = 8'h20;
    exp_b[3] = 8'h10;
    beat_b(1'b1, P0);
    chk_b("b_p0", 1'b0, 2'd1, 8'h01);
    beat_b(1'b1, P1);
    chk_b("b_trig", 1'b1, 2'd0, 8'h01);
    for (int i = 0; i < 4; i++) begin
      beat_b(1'b0, '0);
      chk_b($sformatf("b_rot%0d", i), (i < 3), 2'd0, exp_b[i]);
    end
    beat_b(1'b0, '0);
    chk_b("b_hold", 1'b0, 2'd0, 8'h10);
    beat_b(1'b1, P0);
    chk_b("b_re_p0", 1'b0, 2'd1, 8'h10);
    beat_b(1'b1, P1);
    chk_b("b_retrig", 1'b1, 2'd0, 8'h10);
    beat_b(1'b0, '0);
    chk_b("b_re_rot", 1'b1, 2'd0, 8'h08);
  endtask

  task automatic test_reset_mid_burst;
    beat_b(1'b0, '0);
    chk_b("b_2in", 1'b1, 2'd0, 8'h04);
    @(negedge clk);
    rst_b = 1'b1;
    b_if.state_valid = 1'b1;
    b_if.state = P0;
    @(posedge clk);
    #1;
    chk_b("b_rst_mid", 1'b0, 2'd0, 8'h01);
    beat_b(1'b1, P1);
    chk_b("b_p1_alone", 1'b0, 2'd0, 8'h01);
    beat_b(1'b0, '0);
    chk_b("b_after", 1'b0, 2'd0, 8'h01);
  endtask

  initial begin
    test_reset();
    test_gap_trigger();
    test_ignore_active();
    reset_a_once();
    test_mismatch_restart();
    test_burst();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/tsc_seq_burner.md
# tsc_seq_burner

Parametrised trigger-and-payload block for the AES trust benchmarks, sitting beside the AES core and snooping its round state bus. It arms on a configurable sequence of SEQ_LEN consecutive valid state matches and then drives a rotating high-toggle register (power-burn payload). Two payload modes are supported: permanent, or a bounded burst after which the block re-arms. It generalises the single-pattern, latch-forever trigger to multi-stage sequences, configurable widths and burst operation, with fully synchronous logic.

## Interface
- STATE_W, 128: width of the snooped state bus.
- SEQ_LEN, 2: number of consecutive valid states that must match (1..8).
- PATTERNS, {SEQ_LEN x STATE_W}: concatenated match patterns; pattern 0 occupies the LSBs.
- BURN_W, 128: payload register width (even, ≥2).
- SEED, alternating 1010… of BURN_W bits (0xAAAA… for 128): payload reset value.
- MODE, 0: 0 = permanent payload, 1 = burst payload.
- BURST_CYCLES, 1024: rotations per burst in MODE 1 (≥1).
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- state  in  STATE_W  snooped state value.
- state_valid  in  1  qualifies state for the current cycle.
- tj_trig  out  1  high while the payload is active.
- seq_idx  out  $clog2(SEQ_LEN+1)  number of sequence stages currently matched.
- burn_q  out  BURN_W  payload register.

## Operation
- FSM states:
  - IDLE/MATCH (seq_idx 0..SEQ_LEN-1).
  - ACTIVE.
- On a valid cycle in IDLE/MATCH:
  - If state == pattern[seq_idx], seq_idx increments.
  - If that match completes pattern SEQ_LEN-1, the FSM moves to ACTIVE and seq_idx clears to 0.
- On a mismatch, seq_idx restarts:
  - seq_idx = 1 if state == pattern[0].
  - Otherwise seq_idx = 0.
- Invalid cycles (state_valid = 0) hold seq_idx. A match sequence is consecutive in valid beats, not in clocks.
- In ACTIVE:
  - Every clock rotates burn_q right by one: burn_q <= {burn_q[0], burn_q[BURN_W-1:1]}.
  - state and state_valid are ignored.
- MODE 0: ACTIVE persists until rst.
- MODE 1:
  - A burst counter loads BURST_CYCLES-1 on entry to ACTIVE and decrements on each rotation.
  - The rotation made while the counter is 0 is the last one. The FSM then returns to IDLE with seq_idx 0.
  - burn_q holds its last value and is not reloaded with SEED.
  - The block can re-trigger on a new sequence.
- tj_trig = (FSM == ACTIVE), registered.
- Reset values:
  - tj_trig = 0, seq_idx = 0, burn_q = SEED.
  - FSM = IDLE, burst counter = 0.
- Reset mid-ACTIVE or mid-sequence returns every output to its reset value on the next edge.

## Timing
- Final matching valid beat sampled at edge k → tj_trig = 1 after edge k, and burn_q is unchanged at edge k.
- The first rotation occurs at edge k+1.
- MODE 1:
  - Exactly BURST_CYCLES rotations occur, at edges k+1 through k+BURST_CYCLES.
  - tj_trig falls after edge k+BURST_CYCLES.
  - Earliest re-match sampling is edge k+BURST_CYCLES+1.
- SEQ_LEN = 1: a single matching valid beat triggers. Restart rules still apply to subsequent beats.
- Repeated patterns (pattern[i] == pattern[0]) are handled only by the restart rule above. No full KMP back-off is performed.
- rst has priority over every other event on the same edge.

## Structure
- Shared package tsc_pkg holds:
  - The FSM state enum (S_IDLE, S_ACTIVE).
  - The default-seed constant function (alternating bits of width BURN_W).
  - The legal MODE constants (TSC_MODE_PERM, TSC_MODE_BURST).
- One natural sub-module, tsc_rot_reg: a BURN_W-wide register with synchronous load-SEED on rst and a rotate-right enable. The top-level contains the matcher FSM, seq_idx and the burst counter.

## Test plan
- Reset check: SEQ_LEN=2, MODE 0, defaults. Apply rst for 2 clocks → tj_trig=0, seq_idx=0, burn_q=0xAAAA…AAAA.
- Two-stage trigger with a gap: valid pattern0, one invalid beat, then valid pattern1 (e.g. 0x00112233_44556677_8899aabb_ccddeeff) → tj_trig rises after pattern1's edge. burn_q reads 0x5555…5555 one clock later and alternates 0xAAAA…/0x5555… every clock thereafter.
- Mismatch restart: valid pattern0, pattern0, pattern1 → triggers (second pattern0 sets seq_idx=1). A separate run with pattern0, 0x0, pattern1 → no trigger, seq_idx sequence 1,0,0.
- MODE 1 burst: BURST_CYCLES=4, BURN_W=8, SEED=8'b0000_0001. Apply the trigger sequence → burn_q goes 0x80, 0x40, 0x20, 0x10 then holds 0x10. tj_trig is high for exactly 4 clocks. The sequence then retriggers successfully.
- Reset mid-burst: assert rst two clocks into ACTIVE → next edge tj_trig=0, burn_q=SEED, seq_idx=0. Afterwards a single pattern1 alone does not trigger.
- Ignore-while-active: in MODE 0, drive the trigger patterns repeatedly during ACTIVE → seq_idx stays 0 and the rotation stays uninterrupted.
